// File: rtl/adxl355_pkg.sv
// Shared constants and types for the ADXL355 sensor-side blocks: register map,
// SPI command encoding and burst geometry.
package adxl355_pkg;

   localparam logic [7:0] REG_DEVID_AD  = 8'h00;
   localparam logic [7:0] REG_STATUS    = 8'h04;
   localparam logic [7:0] REG_TEMP2     = 8'h06;
   localparam logic [7:0] REG_XDATA3    = 8'h08;
   localparam logic [7:0] REG_FIFO_DATA = 8'h11;
   localparam logic [7:0] REG_RANGE     = 8'h2C;
   localparam logic [7:0] REG_POWER_CTL = 8'h2D;

   localparam logic READ_BIT  = 1'b1;
   localparam logic WRITE_BIT = 1'b0;

   localparam int AXIS_W      = 20;
   localparam int BURST_BYTES = 9;
   localparam int AXIS_BYTES  = 3;
   localparam int CMD_BITS    = 8;
   localparam int DATA_BITS   = BURST_BYTES * 8;
   localparam int FRAME_BITS  = CMD_BITS + DATA_BITS;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETUP,
      ST_SHIFT,
      ST_HOLD
   } rd_state_t;

   // Command byte: 7-bit register address followed by the R/W flag in bit 0.
   function automatic logic [7:0] read_cmd(input logic [7:0] addr);
      return {addr[6:0], READ_BIT};
   endfunction

endpackage

// File: rtl/adxl355_sclk_gen.sv
// SPI mode-0 clock generator: toggles SCLK every half_cycles clocks while
// enabled and flags the cycle before each rising and falling edge.
module adxl355_sclk_gen #(
   parameter int half_cycles = 4
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_en,
   output logic o_sclk,
   output logic o_rise,
   output logic o_fall
);

   localparam int CNT_W = (half_cycles > 1) ? $clog2(half_cycles) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(half_cycles - 1);

   logic [CNT_W-1:0] cnt_reg;
   logic             sclk_reg;
   logic             wrap;

   assign wrap = i_en && (cnt_reg == CNT_LAST);

   // Disabling parks SCLK low with a fresh count, so every burst starts with
   // a full half-period of setup before the first rising edge.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cnt_reg  <= '0;
         sclk_reg <= 1'b0;
      end else if (!i_en) begin
         cnt_reg  <= '0;
         sclk_reg <= 1'b0;
      end else if (wrap) begin
         cnt_reg  <= '0;
         sclk_reg <= ~sclk_reg;
      end else begin
         cnt_reg <= cnt_reg + 1'b1;
      end
   end

   assign o_sclk = sclk_reg;
   assign o_rise = wrap & ~sclk_reg;
   assign o_fall = wrap & sclk_reg;

endmodule

// File: rtl/adxl355_rd.sv
// Burst reader: on each rising sync edge reads XDATA3..ZDATA1 over SPI mode 0
// and presents one X/Y/Z sample with a single-cycle valid strobe.
module adxl355_rd
   import adxl355_pkg::*;
#(
   parameter int         clk_hz   = 40_000_000,
   parameter int         spi_hz   = 5_000_000,
   parameter logic [7:0] reg_addr = REG_XDATA3
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_sync,
   output logic              o_csn,
   output logic              o_sclk,
   output logic              o_mosi,
   input  logic              i_miso,
   output logic [AXIS_W-1:0] o_x,
   output logic [AXIS_W-1:0] o_y,
   output logic [AXIS_W-1:0] o_z,
   output logic              o_valid,
   output logic              o_busy,
   output logic              o_overrun
);

   localparam int H    = clk_hz / (2 * spi_hz);
   localparam int HC_W = (H > 1) ? $clog2(H) : 1;
   localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(H - 1);
   localparam logic [7:0]      CMD       = read_cmd(reg_addr);
   localparam logic [6:0]      CMD_END   = 7'(CMD_BITS);
   localparam logic [6:0]      LAST_BIT  = 7'(FRAME_BITS);

   if (((clk_hz % (2 * spi_hz)) != 0) || (H < 2)) begin : g_bad_ratio
      $error("adxl355_rd: clk_hz/(2*spi_hz) must be an integer >= 2");
   end

   rd_state_t state_reg, state_next;

   logic                 sync_q_reg;
   logic                 csn_reg, csn_next;
   logic                 mosi_reg, mosi_next;
   logic                 busy_reg, busy_next;
   logic                 valid_reg, valid_next;
   logic                 overrun_reg, overrun_next;
   logic [6:0]           bit_cnt_reg, bit_cnt_next;
   logic [HC_W-1:0]      hold_cnt_reg, hold_cnt_next;
   logic [DATA_BITS-1:0] shift_reg, shift_next;
   logic [2:0][AXIS_W-1:0] axis_reg;
   logic [2:0][AXIS_W-1:0] axis_word;

   logic start;
   logic accept;
   logic sclk_en;
   logic sclk_rise;
   logic sclk_fall;

   assign start   = i_sync & ~sync_q_reg;
   // The cycle that returns to IDLE still counts as busy for new starts.
   assign accept  = (state_reg == ST_IDLE) && !valid_reg;
   assign sclk_en = (state_reg == ST_SETUP) || (state_reg == ST_SHIFT);

   adxl355_sclk_gen #(
      .half_cycles(H)
   ) u_sclk (
      .i_clk  (i_clk),
      .i_rst_n(i_rst_n),
      .i_en   (sclk_en),
      .o_sclk (o_sclk),
      .o_rise (sclk_rise),
      .o_fall (sclk_fall)
   );

   // Each axis is the top 20 bits of its three big-endian bytes.
   genvar gi;
   for (gi = 0; gi < 3; gi++) begin : g_axis
      assign axis_word[gi] = shift_reg[DATA_BITS-1-(gi*AXIS_BYTES*8) -: AXIS_W];
   end

   always_comb begin
      state_next    = state_reg;
      csn_next      = csn_reg;
      mosi_next     = mosi_reg;
      busy_next     = busy_reg;
      valid_next    = 1'b0;
      overrun_next  = start & ~accept;
      bit_cnt_next  = bit_cnt_reg;
      hold_cnt_next = hold_cnt_reg;
      shift_next    = shift_reg;

      case (state_reg)
         ST_IDLE: begin
            if (start && accept) begin
               state_next   = ST_SETUP;
               csn_next     = 1'b0;
               busy_next    = 1'b1;
               mosi_next    = CMD[7];
               bit_cnt_next = '0;
            end
         end
         ST_SETUP: begin
            if (sclk_rise) begin
               bit_cnt_next = bit_cnt_reg + 7'd1;
               state_next   = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (sclk_rise) begin
               if (bit_cnt_reg >= CMD_END) begin
                  shift_next = {shift_reg[DATA_BITS-2:0], i_miso};
               end
               bit_cnt_next = bit_cnt_reg + 7'd1;
            end
            // bit_cnt_reg already counts the rise that this fall closes.
            if (sclk_fall) begin
               if (bit_cnt_reg == LAST_BIT) begin
                  state_next    = ST_HOLD;
                  hold_cnt_next = '0;
                  mosi_next     = 1'b0;
               end else if (bit_cnt_reg < CMD_END) begin
                  mosi_next = CMD[~bit_cnt_reg[2:0]];
               end else begin
                  mosi_next = 1'b0;
               end
            end
         end
         ST_HOLD: begin
            if (hold_cnt_reg == HOLD_LAST) begin
               state_next = ST_IDLE;
               csn_next   = 1'b1;
               busy_next  = 1'b0;
               valid_next = 1'b1;
            end else begin
               hold_cnt_next = hold_cnt_reg + 1'b1;
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_reg    <= ST_IDLE;
         sync_q_reg   <= 1'b0;
         csn_reg      <= 1'b1;
         mosi_reg     <= 1'b0;
         busy_reg     <= 1'b0;
         valid_reg    <= 1'b0;
         overrun_reg  <= 1'b0;
         bit_cnt_reg  <= '0;
         hold_cnt_reg <= '0;
         shift_reg    <= '0;
         axis_reg     <= '0;
      end else begin
         state_reg    <= state_next;
         sync_q_reg   <= i_sync;
         csn_reg      <= csn_next;
         mosi_reg     <= mosi_next;
         busy_reg     <= busy_next;
         valid_reg    <= valid_next;
         overrun_reg  <= overrun_next;
         bit_cnt_reg  <= bit_cnt_next;
         hold_cnt_reg <= hold_cnt_next;
         shift_reg    <= shift_next;
         if (valid_next) begin
            axis_reg <= axis_word;
         end
      end
   end

   assign o_csn     = csn_reg;
   assign o_mosi    = mosi_reg;
   assign o_busy    = busy_reg;
   assign o_valid   = valid_reg;
   assign o_overrun = overrun_reg;
   assign o_x       = axis_reg[0];
   assign o_y       = axis_reg[1];
   assign o_z       = axis_reg[2];

endmodule

// File: tb/tb_adxl355_rd.sv
// Bench for adxl355_rd: two instances (5 MHz and 10 MHz SCLK), each with an
// ADXL355 SPI slave model; checks samples, timing, command bits and overruns.
module tb_adxl355_rd;

   localparam int CLK_HZ = 40_000_000;
   localparam int H_A    = 4;
   localparam int H_B    = 2;
   localparam logic [79:0] EXP_MOSI = {8'h11, 72'h0};

   typedef struct packed {
      logic        csn;
      logic        sclk;
      logic        mosi;
      logic        busy;
      logic        valid;
      logic        overrun;
      logic [19:0] x;
      logic [19:0] y;
      logic [19:0] z;
   } pins_t;

   typedef struct packed {
      int          valid_cnt;
      int          valid_cyc;
      int          ovr_cnt;
      int          rise_cnt;
      int          tot_rise;
      logic [79:0] mosi_cap;
      logic [19:0] vx;
      logic [19:0] vy;
      logic [19:0] vz;
      pins_t       p;
   } mon_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  sync;
   logic [71:0] sensor_data [2];
   int          cyc = 0;
   int          total = 0;
   int          bad = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   genvar gi;
   for (gi = 0; gi < 2; gi++) begin : g_u
      logic        csn, sclk, mosi, busy, valid, overrun;
      logic        miso = 1'b0;
      logic [19:0] x, y, z;
      pins_t       pins;
      mon_t        mon = '0;
      logic        prev_csn = 1'b1;
      logic        prev_sclk = 1'b0;
      logic [79:0] frame = '0;
      int          idx = 0;

      adxl355_rd #(
         .clk_hz  (CLK_HZ),
         .spi_hz  ((gi == 0) ? 5_000_000 : 10_000_000),
         .reg_addr(8'h08)
      ) dut (
         .i_clk    (clk),
         .i_rst_n  (rst_n),
         .i_sync   (sync[gi]),
         .o_csn    (csn),
         .o_sclk   (sclk),
         .o_mosi   (mosi),
         .i_miso   (miso),
         .o_x      (x),
         .o_y      (y),
         .o_z      (z),
         .o_valid  (valid),
         .o_busy   (busy),
         .o_overrun(overrun)
      );

      assign pins = {csn, sclk, mosi, busy, valid, overrun, x, y, z};

      // Sensor model: shifts out {don't-care command byte, 9 data bytes} MSB
      // first, changing MISO after each SCLK fall; records MOSI on each rise.
      always @(negedge clk) begin
         if (prev_csn && !csn) begin
            frame        = {8'h00, sensor_data[gi]};
            idx          = 79;
            miso         = frame[79];
            mon.rise_cnt = 0;
            mon.mosi_cap = '0;
         end
         if (!prev_sclk && sclk) begin
            mon.tot_rise = mon.tot_rise + 1;
            if (!csn) begin
               mon.rise_cnt = mon.rise_cnt + 1;
               mon.mosi_cap = {mon.mosi_cap[78:0], mosi};
            end
         end
         if (prev_sclk && !sclk && !csn && idx > 0) begin
            idx  = idx - 1;
            miso = frame[idx];
         end
         if (valid) begin
            mon.valid_cnt = mon.valid_cnt + 1;
            mon.valid_cyc = cyc;
            mon.vx = x;
            mon.vy = y;
            mon.vz = z;
         end
         if (overrun) mon.ovr_cnt = mon.ovr_cnt + 1;
         prev_csn  = csn;
         prev_sclk = sclk;
      end
   end

   function automatic mon_t get_mon(input int u);
      mon_t m;
      if (u == 0) begin
         m   = g_u[0].mon;
         m.p = g_u[0].pins;
      end else begin
         m   = g_u[1].mon;
         m.p = g_u[1].pins;
      end
      return m;
   endfunction

   // Build the 9-byte burst from the intended axis values plus junk nibbles.
   function automatic logic [71:0] make_burst(input logic [19:0] ax, ay, az);
      logic [23:0] wx, wy, wz;
      wx = ax * 16 + 24'($urandom_range(0, 15));
      wy = ay * 16 + 24'($urandom_range(0, 15));
      wz = az * 16 + 24'($urandom_range(0, 15));
      return {wx[23:16], wx[15:8], wx[7:0], wy[23:16], wy[15:8], wy[7:0],
              wz[23:16], wz[15:8], wz[7:0]};
   endfunction

   task automatic run_read(input int u, input logic [19:0] ex, ey, ez, input string tag);
      mon_t m0, m;
      int   s;
      int   h;
      bit   got;
      h = (u == 0) ? H_A : H_B;
      sensor_data[u] = make_burst(ex, ey, ez);
      m0 = get_mon(u);
      @(negedge clk);
      sync[u] = 1'b1;
      @(posedge clk);
      #1;
      s = cyc;
      m = get_mon(u);
      total++;
      if (m.p.csn !== 1'b0 || m.p.busy !== 1'b1) begin
         bad++;
         $display("FAIL %s start: csn=%b busy=%b, required csn=0 busy=1", tag, m.p.csn, m.p.busy);
      end
      got = 0;
      for (int i = 0; i < 2000 && !got; i++) begin
         @(negedge clk);
         if (i == 30) sync[u] = 1'b0;
         #1;
         m = get_mon(u);
         if (m.valid_cnt != m0.valid_cnt) got = 1;
      end
      sync[u] = 1'b0;
      total++;
      if (!got) begin
         bad++;
         $display("FAIL %s timeout: no valid within 2000 cycles, required one", tag);
      end
      repeat (3) @(negedge clk);
      #1;
      m = get_mon(u);
      $display("read %s unit=%0d x=%h y=%h z=%h latency=%0d", tag, u, m.vx, m.vy, m.vz, m.valid_cyc - s + 1);
      total++;
      if (m.valid_cyc - s != 161 * h) begin
         bad++;
         $display("FAIL %s latency: valid at N+%0d, required N+%0d", tag, m.valid_cyc - s + 1, 161 * h + 1);
      end
      total++;
      if (m.vx !== ex || m.vy !== ey || m.vz !== ez) begin
         bad++;
         $display("FAIL %s data: got x=%h y=%h z=%h, required x=%h y=%h z=%h", tag, m.vx, m.vy, m.vz, ex, ey, ez);
      end
      total++;
      if (m.p.x !== ex || m.p.y !== ey || m.p.z !== ez) begin
         bad++;
         $display("FAIL %s hold: outputs x=%h y=%h z=%h, required x=%h y=%h z=%h", tag, m.p.x, m.p.y, m.p.z, ex, ey, ez);
      end
      total++;
      if (m.valid_cnt - m0.valid_cnt != 1 || m.ovr_cnt != m0.ovr_cnt) begin
         bad++;
         $display("FAIL %s strobes: valids=%0d overruns=%0d, required 1 and 0", tag, m.valid_cnt - m0.valid_cnt, m.ovr_cnt - m0.ovr_cnt);
      end
      total++;
      if (m.rise_cnt != 80 || m.mosi_cap !== EXP_MOSI) begin
         bad++;
         $display("FAIL %s command: rises=%0d mosi=%h, required 80 and %h", tag, m.rise_cnt, m.mosi_cap, EXP_MOSI);
      end
      total++;
      if (m.p.csn !== 1'b1 || m.p.busy !== 1'b0 || m.p.sclk !== 1'b0) begin
         bad++;
         $display("FAIL %s idle: csn=%b busy=%b sclk=%b, required 1 0 0", tag, m.p.csn, m.p.busy, m.p.sclk);
      end
   endtask

   task automatic test_reset;
      pins_t rp;
      mon_t  m;
      rp     = '0;
      rp.csn = 1'b1;
      rst_n  = 1'b0;
      sync   = 2'b00;
      repeat (3) @(negedge clk);
      #1;
      for (int u = 0; u < 2; u++) begin
         m = get_mon(u);
         total++;
         if (m.p !== rp) begin
            bad++;
            $display("FAIL reset_values unit%0d: pins=%h, required %h", u, m.p, rp);
         end
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      #1;
      m = get_mon(0);
      total++;
      if (m.tot_rise != 0 || m.p.csn !== 1'b1) begin
         bad++;
         $display("FAIL reset_idle: rises=%0d csn=%b, required 0 and 1", m.tot_rise, m.p.csn);
      end
   endtask

   task automatic test_single_read;
      run_read(0, 20'h12345, 20'hFFFF0, 20'h80000, "single");
      run_read(0, 20'h7FFFF, 20'h00000, 20'hFFFFF, "extremes");
   endtask

   task automatic test_random_reads;
      for (int i = 0; i < 4; i++) begin
         run_read(0, 20'($urandom), 20'($urandom), 20'($urandom), "random");
         repeat (5) @(negedge clk);
      end
   endtask

   task automatic test_overrun;
      mon_t        m0, m;
      int          s;
      logic [19:0] ex, ey, ez;
      ex = 20'($urandom);
      ey = 20'($urandom);
      ez = 20'($urandom);
      sensor_data[0] = make_burst(ex, ey, ez);
      m0 = get_mon(0);
      @(negedge clk);
      sync[0] = 1'b1;
      @(posedge clk);
      #1;
      s = cyc;
      while (cyc < s + 720) begin
         @(negedge clk);
         case (cyc - s)
            49:  sync[0] = 1'b0;
            99:  sync[0] = 1'b1;
            120: sync[0] = 1'b0;
            644: sync[0] = 1'b1;
            660: sync[0] = 1'b0;
            default: ;
         endcase
      end
      #1;
      m = get_mon(0);
      $display("read overrun unit=0 x=%h y=%h z=%h overruns=%0d", m.vx, m.vy, m.vz, m.ovr_cnt - m0.ovr_cnt);
      total++;
      if (m.ovr_cnt - m0.ovr_cnt != 2) begin
         bad++;
         $display("FAIL overrun_count: got %0d pulses, required 2", m.ovr_cnt - m0.ovr_cnt);
      end
      total++;
      if (m.valid_cnt - m0.valid_cnt != 1 || m.valid_cyc - s != 644) begin
         bad++;
         $display("FAIL overrun_valid: valids=%0d at N+%0d, required 1 at N+645", m.valid_cnt - m0.valid_cnt, m.valid_cyc - s + 1);
      end
      total++;
      if (m.tot_rise - m0.tot_rise != 80) begin
         bad++;
         $display("FAIL overrun_sclk: got %0d rises, required 80", m.tot_rise - m0.tot_rise);
      end
      total++;
      if (m.vx !== ex || m.vy !== ey || m.vz !== ez) begin
         bad++;
         $display("FAIL overrun_data: got %h %h %h, required %h %h %h", m.vx, m.vy, m.vz, ex, ey, ez);
      end
   endtask

   task automatic test_back_to_back;
      mon_t        m0, mb, m;
      int          s;
      logic [19:0] ex, ey, ez;
      m0 = get_mon(0);
      for (int i = 0; i < 5; i++) begin
         ex = 20'($urandom);
         ey = 20'($urandom);
         ez = 20'($urandom);
         sensor_data[0] = make_burst(ex, ey, ez);
         mb = get_mon(0);
         @(negedge clk);
         sync[0] = 1'b1;
         @(posedge clk);
         #1;
         s = cyc;
         while (cyc < s + 349) @(negedge clk);
         sync[0] = 1'b0;
         while (cyc < s + 698) @(negedge clk);
         #1;
         m = get_mon(0);
         $display("read b2b%0d unit=0 x=%h y=%h z=%h latency=%0d", i, m.vx, m.vy, m.vz, m.valid_cyc - s + 1);
         total++;
         if (m.valid_cnt - mb.valid_cnt != 1 || m.valid_cyc - s != 644) begin
            bad++;
            $display("FAIL b2b%0d valid: count=%0d at N+%0d, required 1 at N+645", i, m.valid_cnt - mb.valid_cnt, m.valid_cyc - s + 1);
         end
         total++;
         if (m.vx !== ex || m.vy !== ey || m.vz !== ez) begin
            bad++;
            $display("FAIL b2b%0d data: got %h %h %h, required %h %h %h", i, m.vx, m.vy, m.vz, ex, ey, ez);
         end
      end
      m = get_mon(0);
      total++;
      if (m.ovr_cnt != m0.ovr_cnt || m.valid_cnt - m0.valid_cnt != 5) begin
         bad++;
         $display("FAIL b2b_totals: overruns=%0d valids=%0d, required 0 and 5", m.ovr_cnt - m0.ovr_cnt, m.valid_cnt - m0.valid_cnt);
      end
   endtask

   task automatic test_reset_mid;
      mon_t m0, m;
      int   s;
      sensor_data[0] = make_burst(20'($urandom), 20'($urandom), 20'($urandom));
      m0 = get_mon(0);
      @(negedge clk);
      sync[0] = 1'b1;
      @(posedge clk);
      #1;
      s = cyc;
      while (cyc < s + 299) begin
         @(negedge clk);
         if (cyc - s == 30) sync[0] = 1'b0;
      end
      rst_n = 1'b0;
      #1;
      m = get_mon(0);
      total++;
      if (m.p.csn !== 1'b1 || m.p.busy !== 1'b0 || m.p.sclk !== 1'b0) begin
         bad++;
         $display("FAIL reset_mid_async: csn=%b busy=%b sclk=%b, required 1 0 0", m.p.csn, m.p.busy, m.p.sclk);
      end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      #1;
      m = get_mon(0);
      total++;
      if (m.valid_cnt != m0.valid_cnt || m.p.x !== 20'h0 || m.p.y !== 20'h0 || m.p.z !== 20'h0) begin
         bad++;
         $display("FAIL reset_mid_outputs: valids=%0d x=%h y=%h z=%h, required 0 valids and zeros", m.valid_cnt - m0.valid_cnt, m.p.x, m.p.y, m.p.z);
      end
      run_read(0, 20'($urandom), 20'($urandom), 20'($urandom), "after_reset");
   endtask

   task automatic test_sweep;
      run_read(1, 20'h12345, 20'hFFFF0, 20'h80000, "sweep");
      run_read(1, 20'($urandom), 20'($urandom), 20'($urandom), "sweep_rand");
   endtask

   initial begin
      #900_000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      sensor_data[0] = '0;
      sensor_data[1] = '0;
      test_reset();
      test_single_read();
      test_random_reads();
      test_overrun();
      test_back_to_back();
      test_reset_mid();
      test_sweep();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
